// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with sequential stepping, redirects, trap vectoring,
// alignment checking and a circular return-address stack with sticky error flags.
module pc_sequencer #(
  parameter int              XLEN         = 32,
  parameter int              STEP         = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h100,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           load,
  input  logic                           call,
  input  logic                           ret,
  input  logic                           trap,
  input  logic [XLEN-1:0]                addr,
  output logic [XLEN-1:0]                pc,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           misaligned,
  output logic                           ras_overflow,
  output logic                           ras_underflow
);

  localparam int              CW         = $clog2(RAS_DEPTH + 1);
  localparam int              PW         = $clog2(RAS_DEPTH);
  localparam logic [XLEN-1:0] STEP_V     = XLEN'(STEP);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(STEP - 1);

  // Top-of-stack pointer wraps at RAS_DEPTH, which need not be a power of two
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RAS_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
    return (p == '0) ? PW'(RAS_DEPTH - 1) : p - 1'b1;
  endfunction

  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]   top;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] pc_next;
  logic            misaligned_q;
  logic            bad_align;
  logic            ras_full;
  logic            do_trap;
  logic            do_load;
  logic            do_misalign;
  logic            do_push;
  logic            do_ret;
  logic            do_pop;
  logic            do_under;

  assign seq_pc      = pc + STEP_V;
  assign bad_align   = |(addr & ALIGN_MASK);
  assign ras_full    = (ras_count == CW'(RAS_DEPTH));
  assign do_trap     = enable & trap;
  assign do_load     = enable & ~trap & load;
  assign do_misalign = do_load & bad_align;
  assign do_push     = do_load & ~bad_align & call;
  assign do_ret      = enable & ~trap & ~load & ret;
  assign do_pop      = do_ret & (ras_count != '0);
  assign do_under    = do_ret & (ras_count == '0);

  always_comb begin
    pc_next = seq_pc;
    if (do_trap || do_misalign) pc_next = TRAP_VECTOR;
    else if (do_load)           pc_next = addr;
    else if (do_pop)            pc_next = ras_mem[top];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc            <= RESET_VECTOR;
      ras_count     <= '0;
      top           <= '0;
      misaligned_q  <= 1'b0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      misaligned_q <= do_misalign;
      if (enable) begin
        pc <= pc_next;
        if (do_push) begin
          top <= ptr_inc(top);
          if (ras_full) ras_overflow <= 1'b1;
          else          ras_count    <= ras_count + 1'b1;
        end else if (do_pop) begin
          top       <= ptr_dec(top);
          ras_count <= ras_count - 1'b1;
        end
        if (do_under) ras_underflow <= 1'b1;
      end
    end
  end

  // Stack storage carries no reset; a push when full overwrites the oldest slot
  always_ff @(posedge clk) begin
    if (do_push) ras_mem[ptr_inc(top)] <= seq_pc;
  end

  // The pulse is masked while stalled so a held cycle never shows a stale flag
  assign misaligned = misaligned_q & enable;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised next-generation program counter for the fetch stage.
- Adds configurable width, step, reset and trap vectors, a call/return stack (RAS), alignment checking and sticky error flags.
- Sits between the decode/branch logic, which supplies redirect requests, and instruction memory, which consumes `pc`.

Parameters:
- XLEN, 32, width of the PC and address datapath.
- STEP, 4, increment per sequential advance; must be a power of two, at least 1.
- RESET_VECTOR, 0, value loaded into `pc` on reset; must be STEP-aligned.
- TRAP_VECTOR, 32'h100, redirect target for trap and misaligned load; must be STEP-aligned.
- RAS_DEPTH, 4, number of return-address entries; must be at least 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- enable  in  1  advance permission; when low, all state holds and all requests are ignored.
- load  in  1  redirect `pc` to `addr`.
- call  in  1  qualifier for `load`: also pushes `pc + STEP` onto the RAS.
- ret  in  1  redirect `pc` to the RAS top and pop.
- trap  in  1  redirect `pc` to TRAP_VECTOR.
- addr  in  XLEN  load target.
- pc  out  XLEN  current program counter.
- ras_count  out  $clog2(RAS_DEPTH+1)  number of valid RAS entries.
- misaligned  out  1  registered one-cycle pulse on a misaligned load.
- ras_overflow  out  1  sticky: a push occurred while the RAS was full.
- ras_underflow  out  1  sticky: a pop occurred while the RAS was empty.

Behaviour:
- Reset (async, immediate):
  - `pc` = RESET_VECTOR.
  - `ras_count` = 0, `misaligned` = 0, `ras_overflow` = 0, `ras_underflow` = 0.
  - RAS contents are don't-care.
- All updates occur on posedge `clk`, only when `enable` = 1, and take effect one cycle after the request.
- Priority per enabled cycle (exactly one action):
  1. `trap`: `pc` <= TRAP_VECTOR. RAS untouched.
  2. `load`:
     - If `addr[log2(STEP)-1:0]` != 0: `pc` <= TRAP_VECTOR, `misaligned` pulses for 1 cycle, no push.
     - Otherwise: `pc` <= `addr`, and if `call` = 1, push `pc + STEP`.
  3. `ret`:
     - If `ras_count` > 0: `pc` <= top entry, `ras_count` decrements.
     - If empty: `pc` <= `pc + STEP`, `ras_underflow` set.
  4. None of the above: `pc` <= `pc + STEP`.
- `call` without `load` is ignored. `ret` is ignored when `trap` or `load` wins.
- The RAS is a circular buffer with a top pointer.
  - Push when full overwrites the oldest entry, `ras_count` stays RAS_DEPTH, `ras_overflow` set.
  - A subsequent pop returns the newest entries in LIFO order; after RAS_DEPTH pops the stack reads as empty.
- Arithmetic is modulo 2^XLEN: `pc` = 2^XLEN - STEP wraps to 0 with no flag. A pushed return address wraps the same way.
- `misaligned` is 0 on every cycle other than the one following a misaligned load. It also reads 0 on cycles where `enable` = 0.
- Sticky flags clear only on reset.
- Reset asserted mid-operation: every output returns to its reset value immediately, independent of `clk`. The first enabled cycle after reset deassertion advances from RESET_VECTOR.

Test Plan:
- Reset and step: RESET_VECTOR = 0x80, STEP = 4, `enable` held 1 for 3 cycles after reset -> `pc` = 0x80, 0x84, 0x88, 0x8C. With `enable` = 0 and `load` = 1, `pc` holds 0x8C.
- Call and return: at `pc` = 0x10, `load` = 1, `call` = 1, `addr` = 0x200 -> `pc` = 0x200, `ras_count` = 1. Two steps later `ret` = 1 -> `pc` = 0x14, `ras_count` = 0.
- Overflow and wrap:
  - RAS_DEPTH = 4; 5 nested calls pushing return addresses 0x04, 0x104, 0x204, 0x304, 0x404 -> `ras_overflow` = 1, `ras_count` = 4.
  - 4 returns yield 0x404, 0x304, 0x204, 0x104.
  - A 5th `ret` gives `pc` + 4 and sets `ras_underflow` = 1.
- Priority: `trap`, `load` (`addr` = 0x40) and `ret` all asserted with `ras_count` = 2 -> `pc` = TRAP_VECTOR, `ras_count` stays 2. Next cycle, `load` + `ret` -> `pc` = 0x40, `ras_count` stays 2.
- Misalign: `load` with `addr` = 0x42 -> `pc` = 0x100, `misaligned` high for exactly one cycle, no push even with `call` = 1.
- Wrap and async reset: XLEN = 32, `pc` = 0xFFFFFFFC, step -> `pc` = 0x0. Assert `rst` mid-cycle between clock edges -> `pc` = RESET_VECTOR and both sticky flags clear before the next edge.
